// File: rtl/periph_bus_fabric.sv
// rtl/periph_bus_fabric.sv - register-page fabric: slot decode, latched wait select, watchdog, error log
// Define FABRIC_STATUS_EN to expose err_count/err_addr/flags at slot FABRIC_SLOT.
module periph_bus_fabric #(
  parameter logic [7:0] REG_PAGE       = 8'hFF,
  parameter int         NUM_SLOTS      = 4,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] ABORT_DATA     = 8'hFF,
  parameter int         FABRIC_SLOT    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            bus_address,
  input  logic [7:0]             bus_data_tx,
  output logic [7:0]             bus_data_rx,
  input  logic                   bus_read,
  input  logic                   bus_write,
  output logic                   bus_wait,
  output logic                   mem_read,
  output logic                   mem_write,
  input  logic [7:0]             mem_data_rx,
  input  logic                   mem_wait,
  output logic [3:0]             slot_address,
  output logic [7:0]             slot_data_tx,
  output logic [NUM_SLOTS-1:0]   slot_read,
  output logic [NUM_SLOTS-1:0]   slot_write,
  input  logic [8*NUM_SLOTS-1:0] slot_data_rx,
  input  logic [NUM_SLOTS-1:0]   slot_wait
);

`ifdef FABRIC_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] wdog_q, wdog_d;
  logic [7:0] err_count_q, err_count_d;
  logic [7:0] err_addr_q, err_addr_d;
  logic [1:0] flags_q, flags_d;

  logic       is_reg, strobe, wr_eff, slot_hit, status_hit;
  logic [3:0] idx, rt_idx;
  logic       rt_en, rt_wait, log_err;
  logic [7:0] rt_data, status_data, wdog_inc;
  logic [1:0] err_flag;

  assign slot_address = bus_address[3:0];
  assign slot_data_tx = bus_data_tx;
  assign is_reg       = (bus_address[15:8] == REG_PAGE);
  assign idx          = bus_address[7:4];
  assign strobe       = bus_read | bus_write;
  assign wr_eff       = bus_write & ~bus_read;
  assign slot_hit     = ({1'b0, idx} < 5'(NUM_SLOTS));
  assign status_hit   = STATUS_EN && (idx == 4'(FABRIC_SLOT));
  assign wdog_inc     = wdog_q + 8'd1;
  // Once waiting, routing follows the latched slot, not the live address.
  assign rt_idx       = (state_q == IDLE) ? idx : sel_q;

  always_comb begin
    rt_data = 8'h00;
    rt_wait = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rt_idx == 4'(i)) begin
        rt_data = slot_data_rx[8*i +: 8];
        rt_wait = slot_wait[i];
      end
    end
  end

  always_comb begin
    case (bus_address[3:0])
      4'd0:    status_data = err_count_q;
      4'd1:    status_data = err_addr_q;
      4'd2:    status_data = {6'b0, flags_q};
      default: status_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wdog_d      = wdog_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    flags_d     = flags_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    bus_data_rx = 8'h00;
    bus_wait    = 1'b0;
    rt_en       = 1'b0;
    log_err     = 1'b0;
    err_flag    = 2'b00;
    case (state_q)
      IDLE: begin
        if (!is_reg) begin
          mem_read    = bus_read;
          mem_write   = bus_write;
          bus_data_rx = mem_data_rx;
          bus_wait    = mem_wait;
        end else if (slot_hit) begin
          rt_en       = 1'b1;
          bus_data_rx = rt_data;
          bus_wait    = rt_wait;
          if (strobe && rt_wait) begin
            sel_d   = idx;
            wdog_d  = 8'd1;
            state_d = ACCESS;
          end
        end else if (status_hit) begin
          bus_data_rx = status_data;
          if (wr_eff && bus_address[3:0] == 4'd0) begin
            err_count_d = 8'h00;
            flags_d     = 2'b00;
          end
        end else if (strobe) begin
          log_err  = 1'b1;
          err_flag = 2'b10;
        end
      end
      ACCESS: begin
        bus_data_rx = rt_data;
        bus_wait    = rt_wait;
        if (!strobe) begin
          state_d = IDLE;
        end else begin
          rt_en = 1'b1;
          if (!rt_wait) begin
            state_d = IDLE;
          end else begin
            wdog_d = wdog_inc;
            if (wdog_inc == 8'(TIMEOUT_CYCLES)) begin
              state_d  = ABORT;
              log_err  = 1'b1;
              err_flag = 2'b01;
            end
          end
        end
      end
      ABORT: begin
        bus_data_rx = ABORT_DATA;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (log_err) begin
      err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
      err_addr_d  = bus_address[7:0];
      flags_d     = flags_q | err_flag;
    end
  end

  always_comb begin
    slot_read  = '0;
    slot_write = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_read[i]  = rt_en && bus_read && (rt_idx == 4'(i));
      slot_write[i] = rt_en && wr_eff && (rt_idx == 4'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 4'd0;
      wdog_q      <= 8'd0;
      err_count_q <= 8'd0;
      err_addr_q  <= 8'd0;
      flags_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wdog_q      <= wdog_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: doc/periph_bus_fabric.md
Name: periph_bus_fabric

Overview:
- Parametrised register-space interconnect between the CPU bus and N peripheral wrappers, plus a pass-through path to the memory controller.
- Replaces fixed decode of a 3-slot register page; generalises to NUM_SLOTS slots with a configurable page and slot field.
- Adds sequential behaviour the fixed decode lacks: a latched slot select held during wait states, a watchdog that aborts stuck peripheral accesses, and error accounting.

Parameters:
REG_PAGE, 8'hFF, value of bus_address[15:8] that selects register space
NUM_SLOTS, 4, number of peripheral slots, 1..15
TIMEOUT_CYCLES, 255, wait cycles before an access is aborted, 2..255
ABORT_DATA, 8'hFF, read data returned on an aborted read
FABRIC_SLOT, 15, slot index of the fabric's own status registers, must be >= NUM_SLOTS

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
bus_address  input  16  CPU address
bus_data_tx  input  8  CPU write data
bus_data_rx  output  8  CPU read data
bus_read  input  1  CPU read strobe, held until !bus_wait
bus_write  input  1  CPU write strobe, held until !bus_wait
bus_wait  output  1  stall to CPU
mem_read  output  1  read strobe to memory controller
mem_write  output  1  write strobe to memory controller
mem_data_rx  input  8  memory read data
mem_wait  input  1  memory stall
slot_address  output  4  bus_address[3:0], shared by all slots
slot_data_tx  output  8  bus_data_tx, shared by all slots
slot_read  output  NUM_SLOTS  one-hot read strobe per slot
slot_write  output  NUM_SLOTS  one-hot write strobe per slot
slot_data_rx  input  8*NUM_SLOTS  slot i read data at [8i+7:8i]
slot_wait  input  NUM_SLOTS  per-slot stall

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. On reset: state=IDLE, wdog=0, err_count=0, err_addr=0, flags=0.
- Decode:
  - reg = (bus_address[15:8]==REG_PAGE); idx = bus_address[7:4].
  - When !reg: mem_read=bus_read, mem_write=bus_write, bus_data_rx=mem_data_rx, bus_wait=mem_wait. These are purely combinational, slot strobes are 0, and the fabric's state is untouched.
  - When reg: mem strobes are 0.
- IDLE (registered-page access):
  - idx < NUM_SLOTS: strobe slot idx combinationally; bus_data_rx and bus_wait come from slot idx.
  - If slot_wait[idx]=1: latch sel=idx, wdog=1, go to ACCESS. Otherwise the access completes in that cycle (zero added latency).
  - idx==FABRIC_SLOT: status register access, see Optional Feature. Never waits.
  - Any other idx is unmapped:
    - bus_wait=0; read returns 8'h00; write is dropped.
    - err_count += 1 (saturates at 255); err_addr=bus_address[7:0]; flags[1]=1.
    - This happens once per strobe cycle.
- ACCESS:
  - The strobe is routed to latched sel, not the live idx; data and wait also come from sel.
  - Each cycle with slot_wait[sel]=1: wdog += 1.
  - slot_wait[sel]=0: access completes this cycle; go to IDLE.
  - Strobes dropped by the CPU (both 0): go to IDLE without an error.
  - wdog==TIMEOUT_CYCLES with wait still high: go to ABORT. Error count, err_addr and flags[0] update as for unmapped.
- ABORT (exactly 1 cycle):
  - All slot strobes are 0 and bus_wait=0.
  - bus_data_rx=ABORT_DATA; writes are discarded.
  - Next state: IDLE.
- Simultaneous events: slot_wait falling on the same cycle wdog reaches TIMEOUT_CYCLES counts as completion, not abort.
- Reset mid-ACCESS: return to IDLE next edge; slot strobes drop immediately after that edge.
- Read and write both asserted is illegal CPU behaviour; the read takes priority and the write strobe is suppressed.

Optional Feature:
- Macro FABRIC_STATUS_EN.
- Defined: slot FABRIC_SLOT is the status block.
  - offset 0 reads err_count; a write of any value clears err_count and flags.
  - offset 1 reads err_addr.
  - offset 2 reads {6'b0, flags}.
  - other offsets read 0.
- Undefined: FABRIC_SLOT decodes as unmapped. Counters still exist internally but are not readable.

Test Plan:
- Read FF12 with slot 1 wait=0 and data 8'h5A -> slot_read=4'b0010; bus_data_rx=5A, bus_wait=0 in the same cycle.
- Read 0x1234 -> mem_read=1, slot strobes 0, bus_data_rx follows mem_data_rx; no state change.
- Write FF20 with slot 2 wait held 3 cycles; change bus_address[7:4] mid-wait -> slot_write stays 4'b0100 throughout; completes on cycle 4; err_count unchanged.
- TIMEOUT_CYCLES=4, read FF05 with slot 0 wait stuck high -> 4 wait cycles, then 1 cycle of bus_wait=0 with data FF; err_count=1, err_addr=05, flags=01.
- Read FF90 (unmapped) twice, then (FABRIC_STATUS_EN) read FFF0 -> 8'h02; read FFF2 -> 8'h02; write FFF0 -> both read 0 afterwards.
- Assert rst during ACCESS -> next cycle state IDLE, slot strobes follow the live decode, err_count=0.
